trigger_sequencer: RTL and testbench
====================================

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 Parameter SIZE, default 32, sample channel count.
REQ-002 Parameter LEVELS, default 8, trigger stage count; LW = $clog2(LEVELS).
REQ-003 Parameter SADDR_W, default 24, sample counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 arm  in  1  one-cycle start request.
REQ-007 abort  in  1  one-cycle cancel request.
REQ-008 sample_valid  in  1  qualifies sample_data for one cycle.
REQ-009 sample_data  in  SIZE  current sample.
REQ-010 trig_mask / trig_type / trig_level  in  LEVELS*SIZE each  per stage k at bits [k*SIZE +: SIZE]; mask=1 enables channel, type 0=level match, 1=edge match.
REQ-011 num_levels  in  LW+1  active stage count.
REQ-012 pre_count / post_count  in  SADDR_W  samples before trigger / samples from trigger inclusive.
REQ-013 armed, triggered, done, capture_en  out  1  status; capture_en marks samples to forward to the FIFO.
REQ-014 stage  out  LW  current trigger stage index.
REQ-015 trigger_pos  out  SADDR_W  index of trigger sample within the capture.

Function
REQ-016 States SHALL be IDLE, PRE, WAIT, POST, DONE; all outputs registered.
REQ-017 arm in IDLE or DONE: next state PRE (WAIT if latched pre_count==0); armed=1, done=0, triggered=0, stage=0, counters cleared; arm ignored in PRE/WAIT/POST.
REQ-018 On arm, pre_count, post_count and num_levels SHALL be latched; num_levels 0 treated as 1, values >LEVELS clamped to LEVELS.
REQ-019 Mask/type/level are read live; they are stable while armed by software contract.
REQ-020 capture_en SHALL equal sample_valid combinationally gated by state in {PRE, WAIT, POST}; each such sample increments sample_count (SADDR_W, saturating at all-ones).
REQ-021 PRE: after pre_count accepted samples, move to WAIT; matching is not evaluated in PRE.
REQ-022 Stage k matches on a valid sample when every masked channel i satisfies: type 0: data[i]==level[i]; type 1: prev[i]!=data[i] and data[i]==level[i].
REQ-023 prev register updates on every valid sample from arm onward; edge terms are false until one valid sample has been seen since arm.
REQ-024 All-zero mask SHALL match on the first valid sample in WAIT.
REQ-025 WAIT match with stage<num_levels-1: stage increments next cycle; at most one stage advances per sample.
REQ-026 WAIT match on last stage: trigger sample; triggered=1 next cycle, trigger_pos=sample_count before increment, state POST, sample counted as post sample 1.
REQ-027 POST: after post_count samples total (including trigger sample) go to DONE; post_count 0 or 1 goes directly WAIT->DONE on trigger sample.
REQ-028 DONE: armed=0, done=1, triggered=1, capture_en=0; held until arm, abort or reset.
REQ-029 abort in any state: IDLE next cycle, armed=triggered=done=0, stage=0, capture_en=0 that cycle; abort with arm in same cycle: abort wins.
REQ-030 Latency: arm at edge t -> armed=1 after edge t; trigger sample at edge t -> triggered=1 after edge t.

Reset
REQ-031 reset SHALL asynchronously force IDLE, all outputs 0, counters, stage, prev and latched config 0; reset mid-capture discards capture with no done.

Verification
REQ-032 pre=4, post=8, 1 stage, mask=0x1 type=0 level=0x1; data 0 for 10 samples then 1 -> trigger on sample 11, trigger_pos=10, done after 18 accepted samples, capture_en count=18.
REQ-033 2 stages: stage0 rising edge ch0, stage1 level ch1=1, pre=0; feed ch1=1 before ch0 edge -> no trigger; after ch0 0->1 then ch1=1 -> stage 0->1->triggered.
REQ-034 Edge stage, first sample after arm has ch0=1 -> no match; second sample 0 then 1 -> match.
REQ-035 abort during POST -> IDLE next cycle, done=0, capture_en=0; arm and abort same cycle from IDLE -> stays IDLE.
REQ-036 post_count=0, mask=0 -> trigger on first WAIT sample, DONE next cycle; arm while WAIT ignored.
REQ-037 reset asserted mid-WAIT between clock edges -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/trigger_sequencer.sv
// Multi-stage logic-analyser trigger sequencer: pre-trigger fill, staged match, post-trigger
// capture, with capture_en marking samples to forward into the sample FIFO.
module trigger_sequencer #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned LEVELS  = 8,
  parameter int unsigned SADDR_W = 24,
  localparam int unsigned LW     = $clog2(LEVELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     sample_valid,
  input  logic [SIZE-1:0]          sample_data,
  input  logic [LEVELS*SIZE-1:0]   trig_mask,
  input  logic [LEVELS*SIZE-1:0]   trig_type,
  input  logic [LEVELS*SIZE-1:0]   trig_level,
  input  logic [LW:0]              num_levels,
  input  logic [SADDR_W-1:0]       pre_count,
  input  logic [SADDR_W-1:0]       post_count,
  output logic                     armed,
  output logic                     triggered,
  output logic                     done,
  output logic                     capture_en,
  output logic [LW-1:0]            stage,
  output logic [SADDR_W-1:0]       trigger_pos
);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e             state_q;
  logic [SADDR_W-1:0] pre_q, post_q, sample_count, post_cnt;
  logic [SADDR_W-1:0] cnt_next, post_next;
  logic [LW-1:0]      last_q, last_d;
  logic [SIZE-1:0]    prev_q;
  logic               seen_q;

  logic [SIZE-1:0] mask_k, type_k, level_k, edge_k, chan_ok;
  logic            match;

  assign capture_en = sample_valid & ~abort &
                      ((state_q == StPre) | (state_q == StWait) | (state_q == StPost));

  assign cnt_next  = (sample_count == '1) ? sample_count : sample_count + SADDR_W'(1);
  assign post_next = (post_cnt == '1) ? post_cnt : post_cnt + SADDR_W'(1);

  // Stage config is read live for the stage currently being evaluated.
  assign mask_k  = trig_mask[stage*SIZE +: SIZE];
  assign type_k  = trig_type[stage*SIZE +: SIZE];
  assign level_k = trig_level[stage*SIZE +: SIZE];
  assign edge_k  = seen_q ? (prev_q ^ sample_data) : '0;
  assign chan_ok = ~mask_k | (~(sample_data ^ level_k) & (~type_k | edge_k));
  assign match   = &chan_ok;

  // Index of the final stage: 0 means one stage, oversized requests clamp to LEVELS.
  always_comb begin
    last_d = '0;
    if (num_levels == '0) begin
      last_d = '0;
    end else if (32'(num_levels) > LEVELS) begin
      last_d = LW'(LEVELS - 1);
    end else begin
      last_d = LW'(32'(num_levels) - 32'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      post_q       <= '0;
      last_q       <= '0;
      sample_count <= '0;
      post_cnt     <= '0;
      prev_q       <= '0;
      seen_q       <= 1'b0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      done         <= 1'b0;
      stage        <= '0;
      trigger_pos  <= '0;
    end else if (abort) begin
      state_q     <= StIdle;
      armed       <= 1'b0;
      triggered   <= 1'b0;
      done        <= 1'b0;
      stage       <= '0;
      trigger_pos <= '0;
    end else begin
      if (capture_en) begin
        prev_q       <= sample_data;
        seen_q       <= 1'b1;
        sample_count <= cnt_next;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            pre_q        <= pre_count;
            post_q       <= post_count;
            last_q       <= last_d;
            sample_count <= '0;
            post_cnt     <= '0;
            prev_q       <= '0;
            seen_q       <= 1'b0;
            stage        <= '0;
            trigger_pos  <= '0;
            armed        <= 1'b1;
            triggered    <= 1'b0;
            done         <= 1'b0;
            state_q      <= (pre_count == '0) ? StWait : StPre;
          end
        end
        StPre: begin
          if (sample_valid && (cnt_next >= pre_q)) state_q <= StWait;
        end
        StWait: begin
          if (sample_valid && match) begin
            if (stage != last_q) begin
              stage <= stage + LW'(1);
            end else begin
              triggered   <= 1'b1;
              trigger_pos <= sample_count;
              post_cnt    <= SADDR_W'(1);
              if (post_q <= SADDR_W'(1)) begin
                state_q <= StDone;
                armed   <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_q <= StPost;
              end
            end
          end
        end
        StPost: begin
          if (sample_valid) begin
            post_cnt <= post_next;
            if (post_next >= post_q) begin
              state_q <= StDone;
              armed   <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: per-cycle comparison against a sample-count model
// plus literal expectations for the directed scenarios.
module tb_trigger_sequencer;
  localparam int SIZE = 32, LEVELS = 8, SADDR_W = 24, LW = 3;

  logic clk = 1'b0, reset = 1'b1, arm = 1'b0, abort = 1'b0, sample_valid = 1'b0;
  logic [SIZE-1:0]        sample_data = '0;
  logic [LEVELS*SIZE-1:0] trig_mask = '0, trig_type = '0, trig_level = '0;
  logic [LW:0]            num_levels = '0;
  logic [SADDR_W-1:0]     pre_count = '0, post_count = '0;
  logic                   armed, triggered, done, capture_en;
  logic [LW-1:0]          stage;
  logic [SADDR_W-1:0]     trigger_pos;

  int errors = 0, checks = 0, cap_cnt = 0;

  trigger_sequencer #(.SIZE(SIZE), .LEVELS(LEVELS), .SADDR_W(SADDR_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_mask(trig_mask), .trig_type(trig_type),
    .trig_level(trig_level), .num_levels(num_levels), .pre_count(pre_count),
    .post_count(post_count), .armed(armed), .triggered(triggered), .done(done),
    .capture_en(capture_en), .stage(stage), .trigger_pos(trigger_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks accepted-sample count and derives the phase from it.
  bit          m_act, m_trig, m_done, m_seen;
  int          m_pre, m_postc, m_last, m_n, m_post, m_stage, m_tpos;
  logic [31:0] m_prev;

  function automatic bit stage_ok(int k, logic [31:0] d);
    for (int i = 0; i < SIZE; i++) begin
      if (trig_mask[k*SIZE+i]) begin
        if (d[i] != trig_level[k*SIZE+i]) return 1'b0;
        if (trig_type[k*SIZE+i] && (!m_seen || m_prev[i] == d[i])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit fin;
    int nl;
    if (reset) begin
      m_act = 0; m_trig = 0; m_done = 0; m_seen = 0; m_pre = 0; m_postc = 0; m_last = 0;
      m_n = 0; m_post = 0; m_stage = 0; m_tpos = 0; m_prev = '0;
    end else if (abort) begin
      m_act = 0; m_trig = 0; m_done = 0; m_stage = 0; m_tpos = 0;
    end else if (!m_act) begin
      if (arm) begin
        nl = int'(num_levels);
        m_last = ((nl == 0) ? 1 : (nl > LEVELS) ? LEVELS : nl) - 1;
        m_pre = int'(pre_count); m_postc = int'(post_count);
        m_act = 1; m_trig = 0; m_done = 0; m_stage = 0; m_tpos = 0;
        m_n = 0; m_post = 0; m_seen = 0; m_prev = '0;
      end
    end else if (sample_valid) begin
      fin = 0;
      if (!m_trig && m_n >= m_pre) begin
        if (stage_ok(m_stage, sample_data)) begin
          if (m_stage < m_last) m_stage++;
          else begin
            m_trig = 1; m_tpos = m_n; m_post = 1; fin = (m_postc <= 1);
          end
        end
      end else if (m_trig) begin
        m_post++;
        fin = (m_post >= m_postc);
      end
      m_prev = sample_data; m_seen = 1; m_n++;
      if (fin) begin m_act = 0; m_done = 1; end
    end
  end

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    chk("capture_en", 32'(capture_en), 32'(sample_valid && m_act && !abort && !reset));
    chk("armed", 32'(armed), 32'(m_act));
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("done", 32'(done), 32'(m_done));
    chk("stage", 32'(stage), 32'(m_stage));
    chk("trigger_pos", 32'(trigger_pos), 32'(m_tpos));
    if (capture_en) cap_cnt++;
  end

  task automatic tick();
    @(posedge clk); #2;
    arm = 0; abort = 0; sample_valid = 0;
  endtask

  task automatic smp(input logic [31:0] d);
    sample_valid = 1; sample_data = d; tick();
  endtask

  task automatic do_arm(input int pre, input int post, input int nl);
    pre_count = SADDR_W'(pre); post_count = SADDR_W'(post); num_levels = (LW+1)'(nl);
    arm = 1; tick();
  endtask

  task automatic set_stage(input int k, input logic [31:0] m, input logic [31:0] t,
                           input logic [31:0] l);
    trig_mask[k*SIZE +: SIZE] = m; trig_type[k*SIZE +: SIZE] = t;
    trig_level[k*SIZE +: SIZE] = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("reset_armed", 32'(armed), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    reset = 0;
    tick();

    // Single level stage, pre=4 post=8, trigger on the 11th sample
    set_stage(0, 32'h1, 32'h0, 32'h1);
    cap_cnt = 0;
    do_arm(4, 8, 1);
    chk("s1_armed", 32'(armed), 32'd1);
    for (int i = 0; i < 10; i++) begin
      smp(32'h0);
      if (i % 3 == 1) tick();
    end
    chk("s1_no_trig", 32'(triggered), 32'd0);
    smp(32'h1);
    chk("s1_trig", 32'(triggered), 32'd1);
    chk("s1_tpos", 32'(trigger_pos), 32'd10);
    for (int i = 0; i < 6; i++) smp(32'h0);
    chk("s1_not_done", 32'(done), 32'd0);
    smp(32'h0);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_armed_off", 32'(armed), 32'd0);
    tick();
    chk("s1_cap_cnt", 32'(cap_cnt), 32'd18);

    // Two stages: ch0 rising edge then ch1 level
    set_stage(0, 32'h1, 32'h1, 32'h1);
    set_stage(1, 32'h2, 32'h0, 32'h2);
    do_arm(0, 3, 2);
    smp(32'h2); smp(32'h2); smp(32'h2);
    chk("s2_stage0", 32'(stage), 32'd0);
    chk("s2_no_trig", 32'(triggered), 32'd0);
    smp(32'h1);
    chk("s2_stage1", 32'(stage), 32'd1);
    smp(32'h2);
    chk("s2_trig", 32'(triggered), 32'd1);
    chk("s2_tpos", 32'(trigger_pos), 32'd4);
    smp(32'h0); smp(32'h0);
    chk("s2_done", 32'(done), 32'd1);
    // Both stages satisfied by one sample still advance only one stage
    do_arm(0, 1, 2);
    smp(32'h0); smp(32'h3);
    chk("s2b_one_step", 32'(triggered), 32'd0);
    smp(32'h3);
    chk("s2b_tpos", 32'(trigger_pos), 32'd2);

    // Edge stage ignores the first sample after arm
    set_stage(0, 32'h1, 32'h1, 32'h1);
    do_arm(0, 2, 1);
    smp(32'h1);
    chk("s3_first_no", 32'(triggered), 32'd0);
    smp(32'h0); smp(32'h1);
    chk("s3_trig", 32'(triggered), 32'd1);
    chk("s3_tpos", 32'(trigger_pos), 32'd2);
    smp(32'h5);

    // Abort in POST, then arm+abort together from IDLE
    set_stage(0, 32'h0, 32'h0, 32'h0);
    do_arm(0, 8, 1);
    smp(32'h7); smp(32'h7);
    sample_valid = 1; abort = 1; #1;
    chk("s4_cap_abort", 32'(capture_en), 32'd0);
    tick();
    chk("s4_armed", 32'(armed), 32'd0);
    chk("s4_done", 32'(done), 32'd0);
    arm = 1; abort = 1; tick();
    chk("s4_arm_abort", 32'(armed), 32'd0);
    smp(32'h1);

    // post=0, num_levels=0, arm ignored while waiting
    do_arm(0, 0, 0);
    tick();
    do_arm(5, 5, 1);
    chk("s5_still_armed", 32'(armed), 32'd1);
    smp(32'h9);
    chk("s5_done", 32'(done), 32'd1);
    chk("s5_tpos", 32'(trigger_pos), 32'd0);

    // num_levels above LEVELS clamps to LEVELS stages (re-arm from DONE)
    trig_mask = '0; trig_type = '0; trig_level = '0;
    do_arm(0, 1, 15);
    for (int i = 0; i < 7; i++) smp(32'(i));
    chk("s6_stage7", 32'(stage), 32'd7);
    chk("s6_no_trig", 32'(triggered), 32'd0);
    smp(32'h0);
    chk("s6_tpos", 32'(trigger_pos), 32'd7);
    chk("s6_done", 32'(done), 32'd1);

    // Asynchronous reset while waiting
    set_stage(0, 32'h1, 32'h0, 32'h1);
    do_arm(0, 4, 1);
    smp(32'h0);
    #1 reset = 1;
    #1;
    chk("s7_armed_async", 32'(armed), 32'd0);
    chk("s7_stage_async", 32'(stage), 32'd0);
    tick(); tick();
    reset = 0;
    tick();
    smp(32'h1);
    chk("s7_idle", 32'(triggered), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
